// File: rtl/acondicionador_botones_if.sv
// Button-conditioner bus: raw buttons and enable in, press pulses and debounced levels out.
// The master side is the stimulus/board, the slave side is the conditioner.
interface acondicionador_botones_if;
    logic       btn_arriba;
    logic       btn_abajo;
    logic       btn_izq;
    logic       btn_der;
    logic       btn_elige;
    logic       habilita;
    logic       boton_arriba_reg;
    logic       boton_abajo_reg;
    logic       boton_izq_reg;
    logic       boton_der_reg;
    logic       boton_elige_reg;
    logic [4:0] boton_activo;

    modport master (
        output btn_arriba, btn_abajo, btn_izq, btn_der, btn_elige, habilita,
        input  boton_arriba_reg, boton_abajo_reg, boton_izq_reg, boton_der_reg,
               boton_elige_reg, boton_activo
    );

    modport slave (
        input  btn_arriba, btn_abajo, btn_izq, btn_der, btn_elige, habilita,
        output boton_arriba_reg, boton_abajo_reg, boton_izq_reg, boton_der_reg,
               boton_elige_reg, boton_activo
    );
endinterface

// File: rtl/acondicionador_botones.sv
// Five-button conditioner: 2-flop sync, per-button debounce FSM, and a priority
// arbiter that emits at most one single-cycle press pulse per clock.
module acondicionador_botones #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     reset_all,
    acondicionador_botones_if.slave  bus
);
    localparam int unsigned     CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned     NB      = 5;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    // Bit order everywhere: {elige, der, izq, abajo, arriba}
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;
    state_t        state_q [NB];
    state_t        state_d [NB];
    logic [CW-1:0] cnt_q   [NB];
    logic [CW-1:0] cnt_d   [NB];
    logic [NB-1:0] confirm;
    logic [NB-1:0] activo;
    logic [NB-1:0] grant;
    logic [NB-1:0] pending_q, pending_d;
    logic [NB-1:0] pulse_q, pulse_d;

    assign raw = {bus.btn_elige, bus.btn_der, bus.btn_izq, bus.btn_abajo, bus.btn_arriba};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // State register
    always_ff @(posedge clk or negedge reset_all) begin
        if (!reset_all) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pending_q <= '0;
            pulse_q   <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pending_q <= pending_d;
            pulse_q   <= pulse_d;
            for (int unsigned i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = REL_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                REL_CHK: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // FSM outputs: press confirmation strobe and debounced level
    always_comb begin
        confirm = '0;
        activo  = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            confirm[i] = (state_q[i] == PRESS_CHK) && sync2_q[i] && (cnt_q[i] == CNT_MAX);
            activo[i]  = (state_q[i] == HELD) || (state_q[i] == REL_CHK);
        end
    end

    // Fixed priority: elige > arriba > abajo > izq > der
    always_comb begin
        grant = '0;
        if      (pending_q[4]) grant[4] = 1'b1;
        else if (pending_q[0]) grant[0] = 1'b1;
        else if (pending_q[1]) grant[1] = 1'b1;
        else if (pending_q[2]) grant[2] = 1'b1;
        else if (pending_q[3]) grant[3] = 1'b1;

        if (bus.habilita) begin
            pending_d = (pending_q & ~grant) | confirm;
            pulse_d   = grant;
        end else begin
            pending_d = '0;
            pulse_d   = '0;
        end
    end

    assign bus.boton_arriba_reg = pulse_q[0];
    assign bus.boton_abajo_reg  = pulse_q[1];
    assign bus.boton_izq_reg    = pulse_q[2];
    assign bus.boton_der_reg    = pulse_q[3];
    assign bus.boton_elige_reg  = pulse_q[4];
    assign bus.boton_activo     = activo;
endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_acondicionador_botones;
    logic clk;
    logic reset_all;
    int   tests_run;
    int   tests_failed;
    logic [4:0] pulses;

    acondicionador_botones_if bus();

    acondicionador_botones #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset_all (reset_all),
        .bus       (bus)
    );

    assign pulses = {bus.boton_elige_reg, bus.boton_der_reg, bus.boton_izq_reg,
                     bus.boton_abajo_reg, bus.boton_arriba_reg};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to the falling edge following the next rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_all      = 1'b1;
        bus.btn_arriba = 1'b0;
        bus.btn_abajo  = 1'b0;
        bus.btn_izq    = 1'b0;
        bus.btn_der    = 1'b0;
        bus.btn_elige  = 1'b0;
        bus.habilita   = 1'b1;
        #1 reset_all   = 1'b0;
        #2;
        tests_run++;
        if (pulses !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_pulses got=%b exp=%b", pulses, 5'b00000);
        end
        tests_run++;
        if (bus.boton_activo !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_activo got=%b exp=%b", bus.boton_activo, 5'b00000);
        end
        @(negedge clk);
        step();
        tests_run++;
        if (pulses !== 5'b00000 || bus.boton_activo !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_held pulses=%b activo=%b exp=0", pulses, bus.boton_activo);
        end
        reset_all = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [4:0] ep, ea;
        bus.btn_arriba = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            ep = (k == 7) ? 5'b00001 : 5'b00000;
            ea = (k >= 6) ? 5'b00001 : 5'b00000;
            tests_run++;
            if (pulses !== ep) begin
                tests_failed++;
                $display("FAIL clean_pulse k=%0d got=%b exp=%b", k, pulses, ep);
            end
            tests_run++;
            if (bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL clean_activo k=%0d got=%b exp=%b", k, bus.boton_activo, ea);
            end
        end
        bus.btn_arriba = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            ea = (k >= 6) ? 5'b00000 : 5'b00001;
            tests_run++;
            if (pulses !== 5'b00000 || bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL clean_release k=%0d pulses=%b activo=%b exp_activo=%b",
                         k, pulses, bus.boton_activo, ea);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] ep, ea;
        bus.btn_der = 1'b1;
        step(); step();
        bus.btn_der = 1'b0;
        step();
        tests_run++;
        if (pulses !== 5'b00000) begin
            tests_failed++;
            $display("FAIL bounce_early got=%b exp=%b", pulses, 5'b00000);
        end
        step();
        bus.btn_der = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            ep = (k == 7) ? 5'b01000 : 5'b00000;
            ea = (k >= 6) ? 5'b01000 : 5'b00000;
            tests_run++;
            if (pulses !== ep || bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL bounce_press k=%0d pulses=%b exp=%b activo=%b exp=%b",
                         k, pulses, ep, bus.boton_activo, ea);
            end
        end
        bus.btn_der = 1'b0;
        repeat (10) step();
        tests_run++;
        if (bus.boton_activo !== 5'b00000) begin
            tests_failed++;
            $display("FAIL bounce_idle got=%b exp=%b", bus.boton_activo, 5'b00000);
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] ep, ea;
        bus.btn_izq    = 1'b1;
        bus.btn_elige  = 1'b1;
        bus.btn_arriba = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            case (k)
                7:       ep = 5'b10000;
                8:       ep = 5'b00001;
                9:       ep = 5'b00100;
                default: ep = 5'b00000;
            endcase
            ea = (k >= 6) ? 5'b10101 : 5'b00000;
            tests_run++;
            if (pulses !== ep || bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL simul k=%0d pulses=%b exp=%b activo=%b exp=%b",
                         k, pulses, ep, bus.boton_activo, ea);
            end
        end
        bus.btn_izq    = 1'b0;
        bus.btn_elige  = 1'b0;
        bus.btn_arriba = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            ea = (k >= 6) ? 5'b00000 : 5'b10101;
            tests_run++;
            if (pulses !== 5'b00000 || bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL simul_release k=%0d pulses=%b activo=%b exp_activo=%b",
                         k, pulses, bus.boton_activo, ea);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [4:0] ep, ea;
        bus.btn_abajo = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            ep = (k == 7) ? 5'b00010 : 5'b00000;
            tests_run++;
            if (pulses !== ep) begin
                tests_failed++;
                $display("FAIL rel_press k=%0d got=%b exp=%b", k, pulses, ep);
            end
        end
        bus.btn_abajo = 1'b0;
        step(); step();
        bus.btn_abajo = 1'b1;
        step(); step();
        bus.btn_abajo = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            ea = (k >= 6) ? 5'b00000 : 5'b00010;
            tests_run++;
            if (pulses !== 5'b00000 || bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL rel_bounce k=%0d pulses=%b activo=%b exp_activo=%b",
                         k, pulses, bus.boton_activo, ea);
            end
        end
    endtask

    task automatic test_habilita();
        logic [4:0] ep, ea;
        bus.habilita  = 1'b0;
        bus.btn_elige = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            ea = (k >= 6) ? 5'b10000 : 5'b00000;
            tests_run++;
            if (pulses !== 5'b00000 || bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL hab_low k=%0d pulses=%b activo=%b exp_activo=%b",
                         k, pulses, bus.boton_activo, ea);
            end
        end
        bus.habilita = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            tests_run++;
            if (pulses !== 5'b00000) begin
                tests_failed++;
                $display("FAIL hab_rise_held k=%0d got=%b exp=%b", k, pulses, 5'b00000);
            end
        end
        bus.btn_elige = 1'b0;
        repeat (10) step();
        bus.btn_elige = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            ep = (k == 7) ? 5'b10000 : 5'b00000;
            tests_run++;
            if (pulses !== ep) begin
                tests_failed++;
                $display("FAIL hab_repress k=%0d got=%b exp=%b", k, pulses, ep);
            end
        end
        bus.btn_elige = 1'b0;
        repeat (10) step();

        // Pending bit set, then enable dropped before it can be served.
        bus.btn_izq = 1'b1;
        for (int k = 0; k < 7; k++) step();
        tests_run++;
        if (bus.boton_activo !== 5'b00100) begin
            tests_failed++;
            $display("FAIL hab_pend_activo got=%b exp=%b", bus.boton_activo, 5'b00100);
        end
        bus.habilita = 1'b0;
        for (int k = 7; k < 12; k++) begin
            step();
            tests_run++;
            if (pulses !== 5'b00000) begin
                tests_failed++;
                $display("FAIL hab_pend_drop k=%0d got=%b exp=%b", k, pulses, 5'b00000);
            end
        end
        bus.habilita = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (pulses !== 5'b00000) begin
                tests_failed++;
                $display("FAIL hab_pend_restore k=%0d got=%b exp=%b", k, pulses, 5'b00000);
            end
        end
        bus.btn_izq = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_async_reset();
        logic [4:0] ep, ea;
        bus.btn_elige  = 1'b1;
        bus.btn_arriba = 1'b1;
        bus.btn_abajo  = 1'b1;
        for (int k = 0; k < 8; k++) step();
        tests_run++;
        if (pulses !== 5'b10000) begin
            tests_failed++;
            $display("FAIL areset_pre got=%b exp=%b", pulses, 5'b10000);
        end
        #2 reset_all = 1'b0;
        #1;
        tests_run++;
        if (pulses !== 5'b00000 || bus.boton_activo !== 5'b00000) begin
            tests_failed++;
            $display("FAIL areset_immediate pulses=%b activo=%b exp=0", pulses, bus.boton_activo);
        end
        bus.btn_elige  = 1'b0;
        bus.btn_arriba = 1'b0;
        bus.btn_abajo  = 1'b0;
        step(); step();
        reset_all = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            tests_run++;
            if (pulses !== 5'b00000 || bus.boton_activo !== 5'b00000) begin
                tests_failed++;
                $display("FAIL areset_after k=%0d pulses=%b activo=%b exp=0",
                         k, pulses, bus.boton_activo);
            end
        end

        // Button held through reset pulses once after release of reset.
        bus.btn_arriba = 1'b1;
        step(); step(); step();
        reset_all = 1'b0;
        step(); step();
        reset_all = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            ep = (k == 7) ? 5'b00001 : 5'b00000;
            ea = (k >= 6) ? 5'b00001 : 5'b00000;
            tests_run++;
            if (pulses !== ep || bus.boton_activo !== ea) begin
                tests_failed++;
                $display("FAIL areset_held k=%0d pulses=%b exp=%b activo=%b exp=%b",
                         k, pulses, ep, bus.boton_activo, ea);
            end
        end
        bus.btn_arriba = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_bounce();
        test_habilita();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
